// File: rtl/cv32e40p_obi_mem_pkg.sv
// Shared types for the behavioural OBI memory responder.
package cv32e40p_obi_mem_pkg;

    localparam int TS_W = 8;

    typedef struct packed {
        logic            is_write;
        logic [31:0]     rdata;
        logic [TS_W-1:0] ts;
    } obi_resp_entry_t;

    typedef enum logic [0:0] {
        GNT_IDLE = 1'b0,
        GNT_WAIT = 1'b1
    } gnt_state_e;

endpackage

// File: rtl/cv32e40p_obi_resp_fifo.sv
// In-order response FIFO holding accepted-but-unanswered transactions.
module cv32e40p_obi_resp_fifo
    import cv32e40p_obi_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            i_push,
    input  obi_resp_entry_t i_entry,
    input  logic            i_pop,
    output obi_resp_entry_t o_head,
    output logic            o_full,
    output logic            o_empty,
    output logic [3:0]      o_count
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
    localparam logic [3:0]       FULL_CNT = 4'(DEPTH);

    // Storage sized to the pointer range so every index is in bounds.
    obi_resp_entry_t  r_buf [2**PTR_W];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [3:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == 4'd0);
    assign o_count = r_count;
    assign o_head  = r_buf[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_buf[r_wptr] <= i_entry;
    end

endmodule

// File: rtl/cv32e40p_obi_mem_responder.sv
// Behavioural OBI memory slave: programmable grant delay, byte-enabled
// writes, word reads, in-order responses after a minimum latency.
module cv32e40p_obi_mem_responder
    import cv32e40p_obi_mem_pkg::*;
#(
    parameter int MEM_DEPTH       = 4096,
    parameter int MAX_OUTSTANDING = 2,
    parameter int GNT_LATENCY     = 0,
    parameter int RVALID_LATENCY  = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    input  logic        stall_i,
    output logic [3:0]  outstanding_o
);

    localparam int              IDX_W   = $clog2(MEM_DEPTH);
    localparam logic [7:0]      GNT_LAT = 8'(GNT_LATENCY);
    localparam logic [TS_W-1:0] RV_LAT  = TS_W'(RVALID_LATENCY);

    logic [31:0]     r_mem [MEM_DEPTH];
    gnt_state_e      r_state;
    logic [7:0]      r_cnt;
    logic [TS_W-1:0] r_ts;
    logic            r_rvalid;
    logic [31:0]     r_rdata;

    logic            w_gnt;
    logic            w_accept;
    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic [3:0]      w_count;
    logic [IDX_W-1:0] w_idx;
    logic [TS_W-1:0] w_age;
    obi_resp_entry_t w_push_entry;
    obi_resp_entry_t w_head;
    logic            w_unused_addr;

    assign w_idx         = addr_i[IDX_W+1:2];
    assign w_unused_addr = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

    // Occupancy is registered, so a same-cycle pop never frees a slot for this grant.
    always_comb begin
        w_gnt = 1'b0;
        if (GNT_LATENCY == 0)
            w_gnt = req_i && !stall_i && !w_full;
        else if (r_state == GNT_WAIT)
            w_gnt = (r_cnt >= GNT_LAT) && !stall_i && !w_full;
    end

    assign gnt_o    = w_gnt;
    assign w_accept = req_i && w_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= GNT_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                GNT_IDLE: begin
                    if (req_i && (GNT_LATENCY > 0)) begin
                        r_state <= GNT_WAIT;
                        r_cnt   <= 8'd1;
                    end
                end
                default: begin
                    if (!req_i || w_accept) begin
                        r_state <= GNT_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Memory deliberately has no reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (w_accept && we_i) begin
            for (int k = 0; k < 4; k++)
                if (be_i[k]) r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
    end

    assign w_push_entry.is_write = we_i;
    assign w_push_entry.rdata    = we_i ? 32'd0 : r_mem[w_idx];
    assign w_push_entry.ts       = r_ts;

    cv32e40p_obi_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_accept),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Modular age is safe: head age never exceeds RVALID_LATENCY + 1.
    assign w_age = r_ts - w_head.ts;
    assign w_pop = !w_empty && (w_age >= RV_LAT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ts     <= '0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_ts     <= r_ts + 1'b1;
            r_rvalid <= w_pop;
            r_rdata  <= (w_pop && !w_head.is_write) ? w_head.rdata : 32'd0;
        end
    end

    assign rvalid_o      = r_rvalid;
    assign rdata_o       = r_rdata;
    assign outstanding_o = w_count;

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
// Directed bench: three responder configs, scoreboard of expected responses.
module tb_cv32e40p_obi_mem_responder;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, we, stall, gnt, rvalid;
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [3:0]  be [3];
    logic [31:0] rdata [3];
    logic [3:0]  outst [3];

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    exp_t        sb [3][$];
    logic [31:0] mdl [3][4096];

    always #5 clk = ~clk;

    // A: defaults. B: long response latency. C: delayed grant.
    cv32e40p_obi_mem_responder #(.MEM_DEPTH(4096), .MAX_OUTSTANDING(2), .GNT_LATENCY(0), .RVALID_LATENCY(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .stall_i(stall[0]),
        .outstanding_o(outst[0]));
    cv32e40p_obi_mem_responder #(.MEM_DEPTH(4096), .MAX_OUTSTANDING(2), .GNT_LATENCY(0), .RVALID_LATENCY(5)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .stall_i(stall[1]),
        .outstanding_o(outst[1]));
    cv32e40p_obi_mem_responder #(.MEM_DEPTH(4096), .MAX_OUTSTANDING(2), .GNT_LATENCY(3), .RVALID_LATENCY(1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]), .we_i(we[2]),
        .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]), .rdata_o(rdata[2]), .stall_i(stall[2]),
        .outstanding_o(outst[2]));

    function automatic int rvl(input int i);
        return (i == 1) ? 5 : 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock; sample outputs 1ns after the edge and score any response.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("outst_max%0d", i), 32'(outst[i] <= 4'd2), 32'd1);
            if (rvalid[i]) begin
                if (sb[i].size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL spurious_rvalid%0d: observed rvalid=1 at cycle %0d, expected none", i, cyc);
                end else begin
                    e = sb[i].pop_front();
                    chk($sformatf("rdata%0d", i), rdata[i], e.d);
                    chk($sformatf("rvalid_cycle%0d", i), 32'(cyc), 32'(e.due));
                end
            end else begin
                chk($sformatf("rdata_idle%0d", i), rdata[i], 32'd0);
            end
        end
    endtask

    task automatic push_exp(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                            input logic [31:0] d);
        exp_t e;
        int   idx;
        idx = int'(a[13:2]);
        if (w) begin
            for (int k = 0; k < 4; k++)
                if (b[k]) mdl[i][idx][8*k +: 8] = d[8*k +: 8];
        end
        e.d   = w ? 32'd0 : mdl[i][idx];
        e.due = cyc + 1 + rvl(i);
        sb[i].push_back(e);
    endtask

    // Hold a request until granted; leaves req high for back-to-back use.
    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output int waits);
        req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
        waits = 0;
        #1;
        while (!gnt[i] && waits < 40) begin
            tick();
            waits++;
            #1;
        end
        if (!gnt[i]) begin
            checks++;
            errors++;
            $error("FAIL grant_timeout%0d: observed no grant in %0d cycles, expected grant", i, waits);
            req[i] = 1'b0;
            return;
        end
        push_exp(i, w, a, b, d);
        tick();
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        while (sb[i].size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk($sformatf("drain%0d", i), 32'(sb[i].size()), 32'd0);
    endtask

    initial begin
        int w, w1, w2, w3, w4;
        req = '0; we = '0; stall = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; wdata[i] = '0; be[i] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_gnt%0d", i), 32'(gnt[i]), 32'd0);
            chk($sformatf("rst_rvalid%0d", i), 32'(rvalid[i]), 32'd0);
            chk($sformatf("rst_rdata%0d", i), rdata[i], 32'd0);
            chk($sformatf("rst_outst%0d", i), 32'(outst[i]), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // Write then read back, same-cycle grants.
        issue(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, w);
        chk("gnt_same_cycle_wr", 32'(w), 32'd0);
        issue(0, 1'b0, 32'h100, 4'h0, 32'h0, w);
        chk("gnt_same_cycle_rd", 32'(w), 32'd0);
        req[0] = 1'b0;
        drain(0);

        // Partial byte-enable merge.
        issue(0, 1'b1, 32'h20, 4'hF, 32'h11223344, w);
        issue(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, w);
        issue(0, 1'b0, 32'h20, 4'h0, 32'h0, w);
        req[0] = 1'b0;
        chk("be_merge_model", mdl[0][8], 32'h11BB33DD);
        drain(0);

        // Address wrap modulo MEM_DEPTH*4.
        issue(0, 1'b1, 32'h4, 4'hF, 32'h55AA1234, w);
        issue(0, 1'b0, 32'h4004, 4'h0, 32'h0, w);
        req[0] = 1'b0;
        drain(0);

        // Long latency: preload, then four back-to-back reads against a 2-deep FIFO.
        for (int k = 0; k < 4; k++)
            issue(1, 1'b1, 32'(4 * k), 4'hF, 32'hB000_0000 + 32'(k), w);
        req[1] = 1'b0;
        drain(1);
        issue(1, 1'b0, 32'h0, 4'h0, 32'h0, w1);
        issue(1, 1'b0, 32'h4, 4'h0, 32'h0, w2);
        issue(1, 1'b0, 32'h8, 4'h0, 32'h0, w3);
        issue(1, 1'b0, 32'hC, 4'h0, 32'h0, w4);
        req[1] = 1'b0;
        chk("full_wait1", 32'(w1), 32'd0);
        chk("full_wait2", 32'(w2), 32'd0);
        chk("full_wait3", 32'(w3), 32'd4);
        chk("full_wait4", 32'(w4), 32'd0);
        drain(1);

        // Reset with two reads outstanding: responses discarded, memory kept.
        issue(1, 1'b0, 32'h0, 4'h0, 32'h0, w);
        issue(1, 1'b0, 32'h4, 4'h0, 32'h0, w);
        req[1] = 1'b0;
        chk("pre_rst_outst", 32'(outst[1]), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outst", 32'(outst[1]), 32'd0);
        chk("mid_rst_rvalid", 32'(rvalid[1]), 32'd0);
        sb[1].delete();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("post_rst_no_rvalid", 32'(rvalid[1]), 32'd0);
        end
        issue(1, 1'b0, 32'h4, 4'h0, 32'h0, w);
        req[1] = 1'b0;
        drain(1);

        // Delayed grant with a stall pulse in cycle 3.
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; be[2] = 4'hF; wdata[2] = 32'h12345678;
        for (int k = 0; k < 5; k++) begin
            stall[2] = (k == 3);
            #1;
            chk($sformatf("gnt_lat_c%0d", k), 32'(gnt[2]), 32'(k == 4));
            if (k == 4) push_exp(2, 1'b1, 32'h40, 4'hF, 32'h12345678);
            tick();
        end
        req[2] = 1'b0;
        stall[2] = 1'b0;
        issue(2, 1'b0, 32'h40, 4'h0, 32'h0, w);
        req[2] = 1'b0;
        chk("gnt_lat_read", 32'(w), 32'd3);
        drain(2);

        repeat (3) tick();
        for (int i = 0; i < 3; i++)
            chk($sformatf("final_empty%0d", i), 32'(sb[i].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cv32e40p_obi_mem_responder.md
Name: cv32e40p_obi_mem_responder

Overview:
- Behavioural OBI responder (memory slave) for the testbench. It is the far end of the core's instruction or data request/grant/rvalid interface.
- Accepts requests with programmable grant behaviour and performs word reads and byte-enabled writes on an internal array.
- Returns responses in order after a fixed minimum latency, with a bounded number of outstanding transactions.
- One instance serves either the instruction port or the data port of the core wrapper in the UVM/bench top.

Parameters:
- MEM_DEPTH, 4096: number of 32-bit words in the internal array; power of two.
- MAX_OUTSTANDING, 2: response FIFO depth, i.e. maximum accepted-but-unanswered transactions; range 1..8.
- GNT_LATENCY, 0: cycles `req_i` must be held before `gnt_o` may assert; 0 means same-cycle grant.
- RVALID_LATENCY, 1: minimum cycles from acceptance to `rvalid_o`; range 1..255.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  request valid.
- gnt_o  out  1  grant; transaction accepted when `req_i && gnt_o`.
- addr_i  in  32  byte address; bits [1:0] ignored.
- we_i  in  1  1 = write, 0 = read.
- be_i  in  4  byte enables (writes only).
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid, one cycle per accepted transaction.
- rdata_o  out  32  read data; 0 when `rvalid_o` = 0 or for write responses.
- stall_i  in  1  bench-driven grant inhibit; forces `gnt_o` = 0 while high.
- outstanding_o  out  4  current FIFO occupancy (debug/coverage).

Behaviour:
- Reset (async assert, sync deassert in the bench):
  - `gnt_o` = 0, `rvalid_o` = 0, `rdata_o` = 0, `outstanding_o` = 0.
  - FIFO emptied, grant wait counter = 0, timestamp counter = 0.
  - Memory array NOT cleared; contents survive reset.
- Reset mid-operation: all outstanding responses are discarded. No `rvalid_o` is issued for them after reset release.
- Word index = `addr_i[$clog2(MEM_DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo MEM_DEPTH*4.
- Grant FSM, states IDLE and WAIT:
  - IDLE: if `req_i` and GNT_LATENCY = 0, `gnt_o` = `req_i && !stall_i && !full` (combinational). If `req_i` and GNT_LATENCY > 0, go to WAIT with cnt = 1.
  - WAIT: `gnt_o` = (cnt >= GNT_LATENCY) && !stall_i && !full. cnt increments, saturating, while `req_i` is held.
  - On acceptance, return to IDLE. Back-to-back requests restart the count.
  - `req_i` dropping in WAIT (protocol violation) returns to IDLE without any effect.
- full = occupancy == MAX_OUTSTANDING. No same-cycle pop credit: a pop in the same cycle does not free a slot for that cycle's grant.
- At acceptance (clock edge with `req_i && gnt_o`):
  - Write: each byte lane with `be_i[k]` = 1 updates `mem[idx][8k+7:8k]`.
  - Read: `mem[idx]` is sampled at acceptance time, so later writes do not alter it.
  - Push the entry {is_write, rdata, ts} into the FIFO, where ts is an 8-bit free-running counter value.
- Response:
  - Head entry is eligible when `(ts_now - head.ts) mod 256 >= RVALID_LATENCY`.
  - When eligible, drive `rvalid_o` = 1 for exactly one cycle (registered output), with `rdata_o` = head.rdata for reads and 0 for writes, then pop.
  - At most one response per cycle, strictly in acceptance order. There is no back-pressure.
- Simultaneous push and pop in one cycle: occupancy unchanged.
- Minimum round trip with GNT_LATENCY = 0 and RVALID_LATENCY = 1: accept at edge N, `rvalid_o` high in the cycle after edge N+1.
- With `req_i` continuously high, RVALID_LATENCY = 1 and MAX_OUTSTANDING >= 2, throughput is one transaction per cycle.
- Timestamp wrap is safe because head age is bounded by RVALID_LATENCY + 1 < 256.

Decomposition:
- Package cv32e40p_obi_mem_pkg:
  - typedef obi_resp_entry_t {logic is_write; logic [31:0] rdata; logic [7:0] ts}.
  - typedef grant FSM enum {GNT_IDLE, GNT_WAIT}.
  - localparam TS_W = 8.
- Sub-module cv32e40p_obi_resp_fifo: parameterised depth, push/pop/full/empty/count. The top module contains the grant FSM, memory array, timestamp counter and response eligibility logic.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x100 with `be_i` = 4'hF, then read 0x100 → `gnt_o` same cycle; `rvalid_o` 2 cycles after each acceptance; read returns 0xDEADBEEF; write response `rdata_o` = 0.
- Write 0x11223344 to 0x20, then write 0xAABBCCDD to 0x20 with `be_i` = 4'b0101, then read 0x20 → 0x11BB33DD.
- MAX_OUTSTANDING = 2, RVALID_LATENCY = 5, 4 back-to-back reads → 2 grants, `gnt_o` low until first `rvalid_o`; 4 in-order responses; `outstanding_o` never exceeds 2.
- GNT_LATENCY = 3, `req_i` held, `stall_i` pulsed high in cycle 3 → `gnt_o` first asserts in cycle 4 after `req_i` rise; no acceptance while `stall_i` = 1.
- 2 reads outstanding, `rst_ni` pulsed low for 1 cycle → no `rvalid_o` after reset; memory still returns the pre-reset written data on re-read.
- Read 0x0000_4004 with MEM_DEPTH = 4096 → returns the word at 0x0004 (address wrap).
